// File: rtl/store_trace_pkg.sv
// Shared types and constants for the store trace FIFO.
// The optional end-of-test detector is enabled with STORE_TRACE_MATCH_EN.
package store_trace_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [31:0] MATCH_ADDR_DEF = 32'd84;
    localparam logic [31:0] MATCH_DATA_DEF = 32'd5;
    localparam int          DROP_CNT_W     = 16;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the FIFO pointers.
module trace_ram
    import store_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output trace_entry_t rdata
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/store_trace_fifo.sv
// Captures core data-memory stores into a FIFO drained over a valid/ready port.
// Define STORE_TRACE_MATCH_EN to add the sticky end-of-test store detector (match port).
module store_trace_fifo
    import store_trace_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] MATCH_ADDR = MATCH_ADDR_DEF,
    parameter logic [31:0] MATCH_DATA = MATCH_DATA_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memwrite,
    input  logic [31:0]               dataadr,
    input  logic [31:0]               writedata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_addr,
    output logic [31:0]               out_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`ifdef STORE_TRACE_MATCH_EN
    ,
    output logic                      match
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    trace_entry_t  wr_entry;
    trace_entry_t  head;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the store.
    assign push      = memwrite && !reset && (!full || pop);
    assign drop      = memwrite && !reset && full && !pop;

    assign wr_entry.addr = dataadr;
    assign wr_entry.data = writedata;

    trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign out_addr = out_valid ? head.addr : '0;
    assign out_data = out_valid ? head.data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
                end
            end
        end
    end

`ifdef STORE_TRACE_MATCH_EN
    // Checked on every store strobe, including ones dropped for lack of space.
    always_ff @(posedge clk) begin
        if (reset) begin
            match <= 1'b0;
        end else if (memwrite && (dataadr == MATCH_ADDR) && (writedata == MATCH_DATA)) begin
            match <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed self-checking bench for store_trace_fifo (DEPTH=8).
// Match-detector checks are compiled in when STORE_TRACE_MATCH_EN is defined.
module tb_store_trace_fifo;
    import store_trace_pkg::*;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
`ifdef STORE_TRACE_MATCH_EN
    logic        match;
`endif

    int tests  = 0;
    int failed = 0;

    store_trace_fifo #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
`ifdef STORE_TRACE_MATCH_EN
        ,
        .match     (match)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
`ifdef STORE_TRACE_MATCH_EN
        chk("rst_match", 32'(match), 0);
`endif

        // ready while empty is ignored
        out_ready = 1'b1;
        tick();
        chk("empty_ready_count", 32'(count), 0);
        out_ready = 1'b0;

        // three stores, then drain
        store(32'h50, 32'h7);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_addr", out_addr, 32'h50);
        store(32'h54, 32'h9);
        store(32'h58, 32'hB);
        chk("t1_count", 32'(count), 3);
        chk("t1_head_addr", out_addr, 32'h50);
        chk("t1_head_data", out_data, 32'h7);
        tick();
        chk("t1_hold_addr", out_addr, 32'h50);
        out_ready = 1'b1;
        tick();
        chk("t1_d1_addr", out_addr, 32'h54);
        chk("t1_d1_data", out_data, 32'h9);
        tick();
        chk("t1_d2_addr", out_addr, 32'h58);
        chk("t1_d2_data", out_data, 32'hB);
        chk("t1_d2_valid", 32'(out_valid), 1);
        tick();
        chk("t1_end_valid", 32'(out_valid), 0);
        chk("t1_end_count", 32'(count), 0);
        chk("t1_end_addr", out_addr, 0);
        out_ready = 1'b0;

        // overflow: 10 stores into 8 slots
        for (int i = 0; i < 10; i++) store(32'h100 + 32'(4 * i), 32'(i + 1));
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop", 32'(drop_cnt), 2);
        chk("ovf_head", out_addr, 32'h100);

        // full with simultaneous store and pop
        out_ready = 1'b1;
        store(32'h200, 32'hAA);
        chk("fullpp_count", 32'(count), 8);
        chk("fullpp_drop", 32'(drop_cnt), 2);
        for (int i = 1; i < 8; i++) begin
            chk("fullpp_drain_addr", out_addr, 32'h100 + 32'(4 * i));
            chk("fullpp_drain_data", out_data, 32'(i + 1));
            tick();
        end
        chk("fullpp_last_addr", out_addr, 32'h200);
        chk("fullpp_last_data", out_data, 32'hAA);
        tick();
        chk("fullpp_empty", 32'(out_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // streaming with ready held high
        for (int i = 0; i < 20; i++) begin
            memwrite  = 1'b1;
            dataadr   = 32'h300 + 32'(4 * i);
            writedata = 32'h1000 + 32'(i);
            tick();
            chk("stream_count", 32'(count), 1);
            chk("stream_addr", out_addr, 32'h300 + 32'(4 * i));
            chk("stream_data", out_data, 32'h1000 + 32'(i));
        end
        memwrite = 1'b0;
        tick();
        chk("stream_end_count", 32'(count), 0);
        chk("stream_drop", 32'(drop_cnt), 2);
        out_ready = 1'b0;

        // reset with entries queued and a store in the reset cycle
        for (int i = 0; i < 5; i++) store(32'h400 + 32'(4 * i), 32'(i));
        chk("pre_rst_count", 32'(count), 5);
        reset     = 1'b1;
        memwrite  = 1'b1;
        dataadr   = 32'h500;
        writedata = 32'h55;
        tick();
        reset    = 1'b0;
        memwrite = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        tick();
        chk("rst_store_ignored", 32'(count), 0);

`ifdef STORE_TRACE_MATCH_EN
        out_ready = 1'b1;
        store(32'd84, 32'd4);
        chk("match_wrong_data", 32'(match), 0);
        store(32'd80, 32'd5);
        chk("match_wrong_addr", 32'(match), 0);
        store(32'd84, 32'd5);
        chk("match_set", 32'(match), 1);
        tick();
        tick();
        chk("match_sticky", 32'(match), 1);
        out_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
